// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path.
package riscv_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        TRAP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_MISALIGNED = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd2;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction memory request/ready handshake between fetch and imem.
interface fetch_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_address;
    logic                  imem_ready;
    logic [DATA_WIDTH-1:0] imem_instruction;

    modport master (
        output imem_req,
        output imem_address,
        input  imem_ready,
        input  imem_instruction
    );

    modport slave (
        input  imem_req,
        input  imem_address,
        output imem_ready,
        output imem_instruction
    );
endinterface

// File: rtl/fetch_controller_sum4.sv
// Sequential-pc adder: next fetch address, wraps modulo 2^WIDTH.
module sum4
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_sum
);
    assign o_sum = i_a + WIDTH'(PC_STEP);
endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the pc, runs the imem handshake, holds the fetched
// instruction for decode, applies redirects and traps on misalignment/timeout.
module fetch_controller
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] initial_address,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_address,
    input  logic                  stall,
    fetch_controller_if.master    imem,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [1:0]            error_code,
    output logic [31:0]           fetch_count
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    fetch_state_t          r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [DATA_WIDTH-1:0] r_instruction, w_instruction_nxt;
    logic [ADDR_WIDTH-1:0] r_instr_pc, w_instr_pc_nxt;
    logic                  r_instr_valid, w_instr_valid_nxt;
    logic [1:0]            r_error_code, w_error_code_nxt;
    logic [31:0]           r_fetch_count, w_fetch_count_nxt;
    logic [TW-1:0]         r_to_cnt, w_to_cnt_nxt;
    logic                  r_redirect_pending, w_redirect_pending_nxt;

    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [TW-1:0]         w_to_inc;
    logic                  w_redir_bad;

    sum4 #(.WIDTH(ADDR_WIDTH)) u_sum4 (
        .i_a   (r_pc),
        .o_sum (w_pc_plus4)
    );

    assign w_to_inc    = r_to_cnt + TW'(1);
    assign w_redir_bad = redirect_valid && (redirect_address[1:0] != 2'b00);

    // Request and address are decoded straight from state so a trap or reset drops them at once.
    assign imem.imem_req     = (r_state == REQ);
    assign imem.imem_address = r_pc;

    assign instr_valid = r_instr_valid;
    assign instruction = r_instruction;
    assign instr_pc    = r_instr_pc;
    assign error_code  = r_error_code;
    assign fetch_count = r_fetch_count;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= BOOT;
            r_pc               <= '0;
            r_instruction      <= DATA_WIDTH'(NOP_INSTRUCTION);
            r_instr_pc         <= '0;
            r_instr_valid      <= 1'b0;
            r_error_code       <= ERR_NONE;
            r_fetch_count      <= '0;
            r_to_cnt           <= '0;
            r_redirect_pending <= 1'b0;
        end else begin
            r_state            <= w_state_nxt;
            r_pc               <= w_pc_nxt;
            r_instruction      <= w_instruction_nxt;
            r_instr_pc         <= w_instr_pc_nxt;
            r_instr_valid      <= w_instr_valid_nxt;
            r_error_code       <= w_error_code_nxt;
            r_fetch_count      <= w_fetch_count_nxt;
            r_to_cnt           <= w_to_cnt_nxt;
            r_redirect_pending <= w_redirect_pending_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt            = r_state;
        w_pc_nxt               = r_pc;
        w_instruction_nxt      = r_instruction;
        w_instr_pc_nxt         = r_instr_pc;
        w_instr_valid_nxt      = r_instr_valid;
        w_error_code_nxt       = r_error_code;
        w_fetch_count_nxt      = r_fetch_count;
        w_to_cnt_nxt           = r_to_cnt;
        w_redirect_pending_nxt = r_redirect_pending;

        case (r_state)
            BOOT: begin
                w_pc_nxt = initial_address;
                if ((initial_address[1:0] != 2'b00) || w_redir_bad) begin
                    w_state_nxt      = TRAP;
                    w_error_code_nxt = ERR_MISALIGNED;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (w_redir_bad) begin
                    w_state_nxt       = TRAP;
                    w_error_code_nxt  = ERR_MISALIGNED;
                    w_instr_valid_nxt = 1'b0;
                end else begin
                    w_to_cnt_nxt = imem.imem_ready ? '0 : w_to_inc;
                    if (redirect_valid) begin
                        // Data returning alongside a redirect is stale; if none returned, drop the next one.
                        w_pc_nxt               = redirect_address;
                        w_redirect_pending_nxt = !imem.imem_ready;
                    end else if (imem.imem_ready) begin
                        if (r_redirect_pending) begin
                            w_redirect_pending_nxt = 1'b0;
                        end else begin
                            w_instruction_nxt = imem.imem_instruction;
                            w_instr_pc_nxt    = r_pc;
                            w_pc_nxt          = w_pc_plus4;
                            w_instr_valid_nxt = 1'b1;
                            w_state_nxt       = VALID;
                        end
                    end
                    if (!imem.imem_ready && (w_to_inc == TW'(TIMEOUT_CYCLES))) begin
                        w_state_nxt      = TRAP;
                        w_error_code_nxt = ERR_TIMEOUT;
                    end
                end
            end
            VALID: begin
                if (w_redir_bad) begin
                    w_state_nxt       = TRAP;
                    w_error_code_nxt  = ERR_MISALIGNED;
                    w_instr_valid_nxt = 1'b0;
                end else if (redirect_valid) begin
                    w_pc_nxt          = redirect_address;
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = REQ;
                end else if (!stall) begin
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = REQ;
                end
            end
            TRAP: begin
                w_instr_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: boot, wait states, stall, redirect, traps, async reset, wrap.
module tb_fetch_controller;
    localparam logic [31:0] MEM_KEY = 32'hA5A5_0F0F;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] initial_address;
    logic        redirect_valid;
    logic [31:0] redirect_address;
    logic        stall;
    logic        ready;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [1:0]  error_code;
    logic [31:0] fetch_count;

    int vectors = 0;
    int errors  = 0;

    fetch_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem ();

    // Memory returns a word derived from its address so stale data is recognisable.
    assign imem.imem_ready       = ready;
    assign imem.imem_instruction = imem.imem_address ^ MEM_KEY;

    fetch_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .initial_address  (initial_address),
        .redirect_valid   (redirect_valid),
        .redirect_address (redirect_address),
        .stall            (stall),
        .imem             (imem),
        .instr_valid      (instr_valid),
        .instruction      (instruction),
        .instr_pc         (instr_pc),
        .error_code       (error_code),
        .fetch_count      (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ MEM_KEY;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the DUT in BOOT at a falling edge.
    task automatic do_reset(input logic [31:0] addr, input logic rdy);
        @(negedge clk);
        reset = 1'b0; initial_address = addr; ready = rdy; stall = 1'b0;
        redirect_valid = 1'b0; redirect_address = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; initial_address = 32'h100; ready = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_address = '0;
        #1;
        vectors++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", imem.imem_req); end
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", instr_valid); end
        vectors++; if (instruction !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", instruction, NOP); end
        vectors++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h exp 0", instr_pc); end
        vectors++; if (error_code !== 2'd0) begin errors++; $display("FAIL rst_err got %0d exp 0", error_code); end
        vectors++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fetch_count); end
        vectors++; if (imem.imem_address !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem.imem_address); end
    endtask

    task automatic test_boot();
        logic [31:0] a;
        do_reset(32'h100, 1'b1);
        step();
        for (int k = 0; k < 3; k++) begin
            a = 32'h100 + 32'(4 * k);
            vectors++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL boot_req[%0d] got %0b exp 1", k, imem.imem_req); end
            vectors++; if (imem.imem_address !== a) begin errors++; $display("FAIL boot_addr[%0d] got %h exp %h", k, imem.imem_address, a); end
            step();
            vectors++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL boot_valid[%0d] got %0b exp 1", k, instr_valid); end
            vectors++; if (instr_pc !== a) begin errors++; $display("FAIL boot_instr_pc[%0d] got %h exp %h", k, instr_pc, a); end
            vectors++; if (instruction !== mem_word(a)) begin errors++; $display("FAIL boot_instr[%0d] got %h exp %h", k, instruction, mem_word(a)); end
            step();
        end
        vectors++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL boot_count got %0d exp 3", fetch_count); end
    endtask

    task automatic test_wait_states();
        do_reset(32'h40, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ready = 1'b1;
            vectors++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL ws_req[%0d] got %0b exp 1", i, imem.imem_req); end
            vectors++; if (imem.imem_address !== 32'h40) begin errors++; $display("FAIL ws_addr[%0d] got %h exp 40", i, imem.imem_address); end
            vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ws_valid[%0d] got %0b exp 0", i, instr_valid); end
            step();
        end
        vectors++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ws_valid_rise got %0b exp 1", instr_valid); end
        vectors++; if (instruction !== mem_word(32'h40)) begin errors++; $display("FAIL ws_instr got %h exp %h", instruction, mem_word(32'h40)); end
    endtask

    // Continues from VALID holding the word at 0x40.
    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL st_valid[%0d] got %0b exp 1", i, instr_valid); end
            vectors++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL st_instr_pc[%0d] got %h exp 40", i, instr_pc); end
            vectors++; if (instruction !== mem_word(32'h40)) begin errors++; $display("FAIL st_instr[%0d] got %h exp %h", i, instruction, mem_word(32'h40)); end
            vectors++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL st_req[%0d] got %0b exp 0", i, imem.imem_req); end
            vectors++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL st_count[%0d] got %0d exp 0", i, fetch_count); end
            step();
        end
        stall = 1'b0;
        step();
        vectors++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL st_release_count got %0d exp 1", fetch_count); end
        vectors++; if (imem.imem_address !== 32'h44) begin errors++; $display("FAIL st_next_addr got %h exp 44", imem.imem_address); end
        vectors++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL st_next_req got %0b exp 1", imem.imem_req); end
    endtask

    task automatic test_redirect();
        do_reset(32'h80, 1'b0);
        step();
        redirect_valid = 1'b1; redirect_address = 32'h200;
        step();
        redirect_valid = 1'b0;
        vectors++; if (imem.imem_address !== 32'h200) begin errors++; $display("FAIL rd_req_addr got %h exp 200", imem.imem_address); end
        step();
        ready = 1'b1;
        step();
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_discard_valid got %0b exp 0", instr_valid); end
        vectors++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL rd_discard_req got %0b exp 1", imem.imem_req); end
        vectors++; if (imem.imem_address !== 32'h200) begin errors++; $display("FAIL rd_discard_addr got %h exp 200", imem.imem_address); end
        step();
        vectors++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rd_target_valid got %0b exp 1", instr_valid); end
        vectors++; if (instr_pc !== 32'h200) begin errors++; $display("FAIL rd_target_pc got %h exp 200", instr_pc); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_address = 32'h300;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got %0b exp 0", instr_valid); end
        vectors++; if (imem.imem_address !== 32'h300) begin errors++; $display("FAIL rd_valid_addr got %h exp 300", imem.imem_address); end
        vectors++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rd_valid_count got %0d exp 0", fetch_count); end
        step();
        vectors++; if (instr_pc !== 32'h300) begin errors++; $display("FAIL rd_300_pc got %h exp 300", instr_pc); end
        step();
        vectors++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL rd_300_count got %0d exp 1", fetch_count); end
        redirect_valid = 1'b1; redirect_address = 32'h400;
        step();
        redirect_valid = 1'b0;
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_coincide_valid got %0b exp 0", instr_valid); end
        vectors++; if (imem.imem_address !== 32'h400) begin errors++; $display("FAIL rd_coincide_addr got %h exp 400", imem.imem_address); end
        step();
        vectors++; if (instr_pc !== 32'h400) begin errors++; $display("FAIL rd_400_pc got %h exp 400", instr_pc); end
        vectors++; if (instruction !== mem_word(32'h400)) begin errors++; $display("FAIL rd_400_instr got %h exp %h", instruction, mem_word(32'h400)); end
    endtask

    task automatic test_errors();
        do_reset(32'h0, 1'b0);
        step();
        redirect_valid = 1'b1; redirect_address = 32'h202;
        step();
        redirect_valid = 1'b0; ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (error_code !== 2'd1) begin errors++; $display("FAIL mis_err[%0d] got %0d exp 1", i, error_code); end
            vectors++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL mis_req[%0d] got %0b exp 0", i, imem.imem_req); end
            step();
        end
        do_reset(32'h102, 1'b1);
        step();
        vectors++; if (error_code !== 2'd1) begin errors++; $display("FAIL boot_mis_err got %0d exp 1", error_code); end
        vectors++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL boot_mis_req got %0b exp 0", imem.imem_req); end
        do_reset(32'h500, 1'b0);
        step();
        for (int i = 0; i < 16; i++) begin
            vectors++; if (imem.imem_req !== 1'b1 || error_code !== 2'd0) begin errors++; $display("FAIL to_wait[%0d] got req %0b err %0d exp req 1 err 0", i, imem.imem_req, error_code); end
            step();
        end
        vectors++; if (error_code !== 2'd2) begin errors++; $display("FAIL to_err got %0d exp 2", error_code); end
        vectors++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL to_req got %0b exp 0", imem.imem_req); end
        ready = 1'b1;
        step();
        vectors++; if (error_code !== 2'd2) begin errors++; $display("FAIL to_hold got %0d exp 2", error_code); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (error_code !== 2'd0) begin errors++; $display("FAIL to_clear got %0d exp 0", error_code); end
    endtask

    task automatic test_async_reset();
        do_reset(32'h100, 1'b0);
        step();
        step();
        vectors++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL ar_pre_req got %0b exp 1", imem.imem_req); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL ar_req got %0b exp 0", imem.imem_req); end
        vectors++; if (imem.imem_address !== 32'h0) begin errors++; $display("FAIL ar_addr got %h exp 0", imem.imem_address); end
        vectors++; if (instruction !== NOP || instr_pc !== 32'h0) begin errors++; $display("FAIL ar_instr got %h/%h exp %h/0", instruction, instr_pc, NOP); end
        ready = 1'b1;
        step();
        vectors++; if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL ar_ignore got req %0b valid %0b exp 0 0", imem.imem_req, instr_valid); end
    endtask

    task automatic test_wrap();
        do_reset(32'hFFFF_FFFC, 1'b1);
        step();
        vectors++; if (imem.imem_address !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got %h exp fffffffc", imem.imem_address); end
        step();
        vectors++; if (instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", instr_pc); end
        step();
        vectors++; if (imem.imem_address !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", imem.imem_address); end
        vectors++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL wrap_count got %0d exp 1", fetch_count); end
    endtask

    initial begin
        reset = 1'b0; initial_address = '0; redirect_valid = 1'b0;
        redirect_address = '0; stall = 1'b0; ready = 1'b0;
        test_reset();
        test_boot();
        test_wait_states();
        test_stall();
        test_redirect();
        test_errors();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
